if_id_buffer: RTL and testbench
===============================

Name: if_id_buffer

Overview:
- Decoupling buffer between the instruction-fetch stage and the decode stage of the RV32I pipeline.
- Captures each fetched {pc, pc4, instruction} triple into a small circular queue and presents the oldest entry to ID with a valid/ready handshake.
- Absorbs ID stalls without re-fetching.
- A flush from branch or jump redirection discards all queued entries so that no wrong-path instruction reaches decode.

Parameters:
- DEPTH, 2: number of queue entries; must be a power of two, at least 2.
- NOP_INST, 32'h0000_0013: instruction driven on out_inst when out_valid=0 (addi x0,x0,0).

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state.
- in_valid  input  1  IF presents a fetched instruction this cycle.
- in_ready  output  1  buffer can accept; equals (count != DEPTH).
- in_pc  input  32  instruction address (IF inst_addr).
- in_pc4  input  32  in_pc + 4 from the IF adder.
- in_inst  input  32  instruction word from instruction memory.
- flush  input  1  redirect (pc_src=1 or jump=2'b10); discards all entries.
- out_valid  output  1  head entry valid for ID.
- out_ready  input  1  ID accepts the head entry; this is the inverse of the ID stall.
- out_pc  output  32  head entry pc.
- out_pc4  output  32  head entry pc4.
- out_inst  output  32  head entry instruction, or NOP_INST when empty.
- out_misalign  output  1  head entry had in_pc[1:0] != 2'b00.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, out_pc=0, out_pc4=0, out_inst=NOP_INST, out_misalign=0.
  - Entry storage contents are don't-care.
- Push condition: push = in_valid & in_ready & ~flush.
  - On push, the entry at wr_ptr ← {in_pc, in_pc4, in_inst, |in_pc[1:0]}.
  - wr_ptr increments modulo DEPTH (natural wrap of a $clog2(DEPTH)-bit pointer).
- Pop condition: pop = out_valid & out_ready & ~flush.
  - On pop, rd_ptr increments modulo DEPTH.
- Occupancy update:
  - count += push − pop.
  - Push and pop in the same cycle leave count unchanged.
- Outputs are combinational from the entry at rd_ptr and count:
  - out_valid = (count != 0).
  - When out_valid=0, out_pc=0, out_pc4=0, out_inst=NOP_INST, out_misalign=0.
- Latency: an instruction pushed at edge N is visible on the outputs after edge N, so it can be consumed in cycle N+1 at the earliest. There is no combinational in→out bypass.
- Full (count==DEPTH):
  - in_ready=0.
  - A simultaneous pop does not enable a push in the same cycle; in_ready does not depend on out_ready.
  - The IF stage holds its PC while in_ready=0.
- Empty (count==0): out_valid=0; out_ready is ignored.
- Flush:
  - Next state is wr_ptr=rd_ptr=0, count=0, regardless of in_valid/out_ready in the same cycle.
  - The flush-cycle input is dropped; the redirected fetch arrives in a later cycle.
  - Flush has priority over push and pop.
- out_ready held low: head entry and all outputs are stable; the queue keeps filling until full.
- Reset asserted mid-operation: immediate clear to reset values; no entry survives.
- Width rules:
  - pc/pc4 are carried verbatim; the buffer does no arithmetic on them.
  - count is $clog2(DEPTH)+1 bits so that the value DEPTH is representable.
- Misalignment: flagged only; the entry is still queued and delivered. Trap handling belongs to a later stage.

Decomposition:
- Shared pipeline package holds:
  - NOP_INST constant (32'h0000_0013).
  - XLEN=32.
  - The fetch-entry typedef {pc, pc4, inst, misalign} (97 bits), reused by the ID stage.
- One natural sub-module, if_id_fifo_mem: a DEPTH×97 register array with a write port and an asynchronous read port.
- Pointer/count control and output muxing stay in if_id_buffer.

Test Plan:
1. Reset, then idle → out_valid=0, out_inst=32'h00000013, count=0, in_ready=1; after reset release with no stimulus, values unchanged.
2. out_ready=0; push pc=0x0, 0x4, 0x8 on consecutive cycles, each with in_valid=1:
   - After 2 pushes: count=2, in_ready=0, out_pc=0x0, out_inst=first word.
   - The third push is not accepted.
3. Full queue, then in_valid=1 and out_ready=1 in the same cycle:
   - Pop only; count 2→1.
   - Next cycle in_ready=1 and the push is accepted; out_pc advances 0x0→0x4.
4. Wrap-around, DEPTH=2, one push and one pop per cycle for 6 instructions at pc 0x100..0x114 → ID receives pc4 0x104..0x118 in order, with no loss or duplication.
5. count=2, assert flush with in_valid=1, pc=0x200 → next cycle count=0, out_valid=0, and pc 0x200 is not stored. A push of pc=0x300 on the following cycle becomes the head.
6. Push in_pc=0x0000_0102 → out_misalign=1 on that entry only. Assert reset while count=1 → outputs return to reset values immediately, with no clock edge needed.

Source files
------------

// File: rtl/if_id_buffer_pkg.sv
// rtl/if_id_buffer_pkg.sv - shared IF/ID pipeline types and constants
package if_id_buffer_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] inst;
    logic            misalign;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);
endpackage

// File: rtl/if_id_fifo_mem.sv
// rtl/if_id_fifo_mem.sv - fetch-entry register array, one write port, async read
module if_id_fifo_mem
  import if_id_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [ENTRY_W-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [ENTRY_W-1:0] o_rdata
);
  // Storage is intentionally not reset; occupancy alone decides what is valid.
  logic [ENTRY_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - circular queue decoupling instruction fetch from decode
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = if_id_buffer_pkg::NOP_INST,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_pc4,
  input  logic [31:0]   in_inst,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_pc4,
  output logic [31:0]   out_inst,
  output logic          out_misalign,
  output logic [CW-1:0] count
);
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic         w_push;
  logic         w_pop;
  fetch_entry_t w_wr_entry;
  fetch_entry_t w_head;

  // in_ready looks only at occupancy, so a full queue never accepts even while popping.
  assign in_ready  = (r_count != CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;

  assign w_wr_entry = '{pc: in_pc, pc4: in_pc4, inst: in_inst, misalign: |in_pc[1:0]};

  if_id_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_entry),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign count        = r_count;
  assign out_pc       = out_valid ? w_head.pc       : '0;
  assign out_pc4      = out_valid ? w_head.pc4      : '0;
  assign out_inst     = out_valid ? w_head.inst     : NOP_INST;
  assign out_misalign = out_valid ? w_head.misalign : 1'b0;
endmodule

// File: tb/tb_if_id_buffer.sv
// tb/tb_if_id_buffer.sv - randomized self-checking bench for if_id_buffer
module tb_if_id_buffer;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready, out_misalign;
  logic [31:0] in_pc, in_pc4, in_inst, out_pc, out_pc4, out_inst;
  logic [1:0]  count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
  } ent_t;

  ent_t        model[$];
  logic [31:0] got_pc4[$];

  if_id_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc4(in_pc4), .in_inst(in_inst), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_pc4(out_pc4), .out_inst(out_inst), .out_misalign(out_misalign),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = model.size();
    check({tag, ".valid"}, 32'(out_valid), 32'(n != 0));
    check({tag, ".count"}, 32'(count), n);
    check({tag, ".in_ready"}, 32'(in_ready), 32'(n != DEPTH));
    if (n != 0) begin
      check({tag, ".pc"}, out_pc, model[0].pc);
      check({tag, ".pc4"}, out_pc4, model[0].pc4);
      check({tag, ".inst"}, out_inst, model[0].inst);
      check({tag, ".misalign"}, 32'(out_misalign), 32'(model[0].pc[1:0] != 2'b00));
    end else begin
      check({tag, ".pc"}, out_pc, 32'h0);
      check({tag, ".pc4"}, out_pc4, 32'h0);
      check({tag, ".inst"}, out_inst, NOP);
      check({tag, ".misalign"}, 32'(out_misalign), 32'h0);
    end
  endtask

  // One clock of stimulus; the queue model follows the push/pop/flush rules directly.
  task automatic step(input string tag, input logic v, input logic [31:0] pc,
                      input logic [31:0] inst, input logic fl, input logic rdy);
    bit do_push, do_pop;
    in_valid = v; in_pc = pc; in_pc4 = pc + 32'd4; in_inst = inst;
    flush = fl; out_ready = rdy;
    do_push = v && (model.size() < DEPTH) && !fl;
    do_pop  = (model.size() != 0) && rdy && !fl;
    if (out_valid && rdy && !fl) got_pc4.push_back(out_pc4);
    @(posedge clk);
    #1;
    if (fl) model.delete();
    else begin
      if (do_pop) void'(model.pop_front());
      if (do_push) model.push_back('{pc, pc + 32'd4, inst});
    end
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0; in_valid = 0; in_pc = 0; in_pc4 = 0; in_inst = 0; flush = 0; out_ready = 0;
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    step("idle", 0, 32'h0, 32'h0, 0, 0);
    check("idle.inst", out_inst, 32'h0000_0013);

    // Fill with ID stalled; third push must be refused.
    step("fill0", 1, 32'h0, 32'hAAAA_0001, 0, 0);
    step("fill1", 1, 32'h4, 32'hAAAA_0002, 0, 0);
    check("full.in_ready", 32'(in_ready), 32'h0);
    check("full.head_inst", out_inst, 32'hAAAA_0001);
    step("fill2", 1, 32'h8, 32'hAAAA_0003, 0, 0);
    check("full.head_pc", out_pc, 32'h0);

    // Full with pop: only the pop happens, then the push lands.
    step("fullpop", 1, 32'h8, 32'hAAAA_0003, 0, 1);
    check("fullpop.count", 32'(count), 32'd1);
    check("fullpop.head", out_pc, 32'h4);
    step("refill", 1, 32'h8, 32'hAAAA_0003, 0, 0);
    check("refill.count", 32'(count), 32'd2);

    // Wrap-around streaming: one in, one out per cycle.
    step("wflush", 0, 32'h0, 32'h0, 1, 0);
    got_pc4.delete();
    step("wrap0", 1, 32'h100, 32'hB000_0000, 0, 0);
    for (int i = 1; i < 6; i++) step("wrap", 1, 32'h100 + 32'(4 * i), 32'hB000_0000 + 32'(i), 0, 1);
    step("wrapdrain", 0, 32'h0, 32'h0, 0, 1);
    check("wrap.n", got_pc4.size(), 6);
    for (int i = 0; i < 6 && i < got_pc4.size(); i++)
      check("wrap.pc4", got_pc4[i], 32'h104 + 32'(4 * i));

    // Flush drops queued entries and the same-cycle input.
    step("fl0", 1, 32'h10, 32'hC000_0001, 0, 0);
    step("fl1", 1, 32'h14, 32'hC000_0002, 0, 0);
    step("flush", 1, 32'h200, 32'hC000_0200, 1, 1);
    check("flush.count", 32'(count), 32'h0);
    step("after", 1, 32'h300, 32'hC000_0300, 0, 0);
    check("after.head", out_pc, 32'h300);

    // Misaligned entry flagged only on itself.
    step("maflush", 0, 32'h0, 32'h0, 1, 0);
    step("ma", 1, 32'h0000_0102, 32'hD000_0001, 0, 0);
    check("ma.flag", 32'(out_misalign), 32'h1);
    step("ma2", 1, 32'h0000_0108, 32'hD000_0002, 0, 0);
    step("ma3", 0, 32'h0, 32'h0, 0, 1);
    check("ma3.flag", 32'(out_misalign), 32'h0);

    // Asynchronous reset mid-operation, no clock edge in between.
    #2;
    reset = 1'b0;
    #1;
    model.delete();
    check_all("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rpc;
      rpc = $urandom();
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      step("rand", 1'($urandom_range(0, 1)), rpc, $urandom(),
           ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
